// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: round-robin arbiter with a registered one-hot grant held until ack
// Defining RR_ARB_TIMEOUT_EN withdraws an unacknowledged grant after TIMEOUT cycles and pulses timeout_pulse.
module rr_onehot_arbiter #(
  parameter int N = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 grant_ack,
  output logic [N-1:0]         grant_onehot,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] ptr
`ifdef RR_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_pulse
`endif
);
  localparam int PW = $clog2(N);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q;
  logic [N-1:0] grant_q;
  logic valid_q, sel_found, expire, release_g;
  logic [PW-1:0] ptr_q, ptr_d, gidx_q, sel_idx;
  int idx;
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end
  always_comb begin
    sel_found = 1'b0;
    sel_idx = '0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!sel_found && req[idx]) begin
        sel_found = 1'b1;
        sel_idx = PW'(idx);
      end
    end
  end
  assign ptr_d = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + 1'b1;
  assign release_g = grant_ack || expire;
`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic to_q;
  assign expire = cnt_q == CW'(TIMEOUT - 1);
  // counter sits at zero in IDLE, so it starts from zero on every new grant
  always_ff @(posedge clk) begin
    cnt_q <= (reset || state_q == IDLE) ? '0 : grant_ack ? cnt_q : cnt_q + 1'b1;
    to_q <= !reset && state_q == GRANT && expire && !grant_ack;
  end
  assign timeout_pulse = to_q;
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q <= '0;
      gidx_q <= '0;
    end else if (state_q == IDLE) begin
      if (sel_found) begin
        state_q <= GRANT;
        grant_q <= N'(1) << sel_idx;
        valid_q <= 1'b1;
        gidx_q <= sel_idx;
      end
    end else if (release_g) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q <= ptr_d;
    end
  end
  assign grant_onehot = grant_q;
  assign grant_valid = valid_q;
  assign ptr = ptr_q;
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb_rr_onehot_arbiter: directed vectors queued as expectations, checked by an independent monitor
module tb_rr_onehot_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] req = '0;
  logic grant_ack = 1'b0;
  logic [15:0] grant_onehot;
  logic grant_valid;
  logic [3:0] ptr;
  logic timeout_pulse;
  typedef struct {
    int due;
    logic [15:0] g;
    logic v;
    logic [3:0] p;
    logic t;
  } exp_t;
  exp_t sb[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
`ifdef RR_ARB_TIMEOUT_EN
  rr_onehot_arbiter #(.N(16), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req(req), .grant_ack(grant_ack),
    .grant_onehot(grant_onehot), .grant_valid(grant_valid), .ptr(ptr),
    .timeout_pulse(timeout_pulse));
`else
  rr_onehot_arbiter #(.N(16), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req(req), .grant_ack(grant_ack),
    .grant_onehot(grant_onehot), .grant_valid(grant_valid), .ptr(ptr));
  assign timeout_pulse = 1'b0;
`endif
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (grant_onehot !== e.g || grant_valid !== e.v || ptr !== e.p || timeout_pulse !== e.t) begin
        miscompares++;
        $display("FAIL vec@%0d: got g=%h v=%b p=%0d t=%b, want g=%h v=%b p=%0d t=%b",
                 cyc, grant_onehot, grant_valid, ptr, timeout_pulse, e.g, e.v, e.p, e.t);
      end
      if ($countones(grant_onehot) > 1 || (!grant_valid && grant_onehot != 16'h0)) begin
        miscompares++;
        $display("FAIL onehot@%0d: got g=%h v=%b, want one-hot and zero when invalid", cyc, grant_onehot, grant_valid);
      end
    end
  end
  task automatic step(input logic r, input logic [15:0] q, input logic a,
                      input logic [15:0] eg, input logic ev, input logic [3:0] ep, input logic et = 1'b0);
    reset = r;
    req = q;
    grant_ack = a;
    sb.push_back('{cyc + 1, eg, ev, ep, et});
    @(posedge clk);
    #1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    repeat (2) step(1, 16'h0, 0, 16'h0, 0, 0);
    repeat (10) step(0, 16'h0, 0, 16'h0, 0, 0);
    step(0, 16'h0, 1, 16'h0, 0, 0);
    repeat (6) step(0, 16'h0004, 0, 16'h0004, 1, 0);
    step(0, 16'h0004, 1, 16'h0, 0, 3);
    step(0, 16'h0, 0, 16'h0, 0, 3);
    step(1, 16'h0, 0, 16'h0, 0, 0);
    step(0, 16'h8001, 0, 16'h0001, 1, 0);
    step(0, 16'h8001, 1, 16'h0, 0, 1);
    step(0, 16'h8001, 0, 16'h8000, 1, 1);
    step(0, 16'h8001, 1, 16'h0, 0, 0);
    step(0, 16'h8001, 0, 16'h0001, 1, 0);
    step(0, 16'h8001, 1, 16'h0, 0, 1);
    step(0, 16'h0, 0, 16'h0, 0, 1);
    step(1, 16'h0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      step(0, 16'hFFFF, 1, 16'h1 << (i % 16), 1, 4'(i % 16));
      step(0, 16'hFFFF, 1, 16'h0, 0, 4'((i + 1) % 16));
    end
    step(0, 16'h0, 0, 16'h0, 0, 1);
    step(1, 16'h0, 0, 16'h0, 0, 0);
    step(0, 16'h0010, 0, 16'h0010, 1, 0);
    repeat (3) step(0, 16'h0, 0, 16'h0010, 1, 0);
    step(0, 16'h0, 1, 16'h0, 0, 5);
    step(0, 16'h0021, 0, 16'h0020, 1, 5);
    step(0, 16'h0, 1, 16'h0, 0, 6);
    step(0, 16'h0021, 0, 16'h0001, 1, 6);
    step(0, 16'h0, 1, 16'h0, 0, 1);
    step(0, 16'h0010, 0, 16'h0010, 1, 1);
    step(1, 16'h0010, 0, 16'h0, 0, 0);
    step(0, 16'h0, 0, 16'h0, 0, 0);
`ifdef RR_ARB_TIMEOUT_EN
    repeat (4) step(0, 16'h0002, 0, 16'h0002, 1, 0);
    step(0, 16'h0002, 0, 16'h0, 0, 2, 1);
    step(0, 16'h0, 0, 16'h0, 0, 2);
    repeat (4) step(0, 16'h0002, 0, 16'h0002, 1, 2);
    step(0, 16'h0, 1, 16'h0, 0, 2);
    step(0, 16'h0, 0, 16'h0, 0, 2);
`endif
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
